serial_adder_nb: RTL and testbench



---
 rtl/serial_adder_nb.sv | 121 ++++++++++++
 tb/tb_serial_adder_nb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_nb.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// WIDTH cycles per operation with a start/busy/done handshake.
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | one operand bit per clock, counter tracks bit index
//   DONE   | one-cycle result strobe; start here is accepted back-to-back
module serial_adder_nb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic sum_bit;
    logic carry_nxt;
    logic last_bit;

    assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    // Subtraction is a + ~b + ~cin, so invert b and seed the carry with ~cin.
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = {sum_bit, r_sh_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // carry_q here is the carry into the MSB.
                    s_d     = {sum_bit, r_sh_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    ovf_d   = carry_q ^ carry_nxt;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_nb.sv
// Self-checking bench for serial_adder_nb (WIDTH=8) against an integer-arithmetic reference.
module tb_serial_adder_nb;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int both_hi  = 0;

    logic [W-1:0] last_s;

    serial_adder_nb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy === 1'b1 && done === 1'b1) both_hi++;

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic isub, input logic icin,
                                  output logic [W-1:0] es, output logic ec, output logic eo);
        int ua, ub, sa, sb, u, r;
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        if (!isub) begin
            u  = ua + ub + int'(icin);
            r  = sa + sb + int'(icin);
            ec = (u > 255);
        end else begin
            u  = ua - ub - int'(icin);
            r  = sa - sb - int'(icin);
            ec = (u >= 0);
        end
        es = W'(u & 255);
        eo = (r > 127) || (r < -128);
    endfunction

    // Caller is at a negedge; returns at the negedge of the DONE cycle.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin, output int lat);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL reset_s got %h want 00", s); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h3C, 8'h5A, 1'b0, 1'b0, lat);
        // Asynchronous reset between clock edges while done is high.
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done got %b want 0", done); end
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL async_reset_s got %h want 00", s); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL async_reset_ovf got %b want 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        last_s = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h3C, 8'hFF, 8'h10, 8'h80};
        logic [W-1:0] vb [4] = '{8'h5A, 8'h01, 8'h20, 8'h01};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] es;
        logic         ec, eo;
        int lat;
        for (int i = 0; i < 4; i++) begin
            model(va[i], vb[i], vs[i], vc[i], es, ec, eo);
            do_op(va[i], vb[i], vs[i], vc[i], lat);
            n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 8", i, lat); end
            n_checks++; if (s !== es) begin n_fail++; $display("FAIL dir%0d_s got %h want %h", i, s, es); end
            n_checks++; if (cout !== ec) begin n_fail++; $display("FAIL dir%0d_cout got %b want %b", i, cout, ec); end
            n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf, eo); end
            last_s = es;
            @(negedge clk);
        end
    endtask

    task automatic test_hold_ignore();
        logic [W-1:0] es;
        logic         ec, eo;
        int n;
        model(8'h3C, 8'h5A, 1'b0, 1'b0, es, ec, eo);
        a = 8'h3C; b = 8'h5A; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            n_checks++; if (s !== last_s) begin n_fail++; $display("FAIL hold_s cyc%0d got %h want %h", n, s, last_s); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy cyc%0d got %b want 1", n, busy); end
            if (n == 3) begin
                start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b1; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL ignore_latency got %0d want 8", n); end
        n_checks++; if (s !== es) begin n_fail++; $display("FAIL ignore_s got %h want %h", s, es); end
        n_checks++; if (cout !== ec) begin n_fail++; $display("FAIL ignore_cout got %b want %b", cout, ec); end
        n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL ignore_ovf got %b want %b", ovf, eo); end
        last_s = es;
    endtask

    // Entered at the negedge of a DONE cycle, so the first op starts back-to-back.
    task automatic test_back_to_back();
        logic [W-1:0] es, ra, rb;
        logic         ec, eo, rs, rc;
        int lat;
        model(8'h01, 8'h02, 1'b0, 1'b0, es, ec, eo);
        do_op(8'h01, 8'h02, 1'b0, 1'b0, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
        n_checks++; if (s !== es) begin n_fail++; $display("FAIL b2b_s got %h want %h", s, es); end
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            model(ra, rb, rs, rc, es, ec, eo);
            do_op(ra, rb, rs, rc, lat);
            n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b%0d_latency got %0d want 8", i, lat); end
            n_checks++; if ({s, cout, ovf} !== {es, ec, eo}) begin
                n_fail++; $display("FAIL b2b%0d_result got s=%h c=%b o=%b want s=%h c=%b o=%b", i, s, cout, ovf, es, ec, eo);
            end
        end
        last_s = es;
    endtask

    task automatic test_random();
        logic [W-1:0] es, ra, rb;
        logic         ec, eo, rs, rc;
        int lat;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            model(ra, rb, rs, rc, es, ec, eo);
            do_op(ra, rb, rs, rc, lat);
            n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want 8", i, lat); end
            n_checks++; if ({s, cout, ovf} !== {es, ec, eo}) begin
                n_fail++;
                $display("FAIL rnd%0d a=%h b=%h sub=%b cin=%b got s=%h c=%b o=%b want s=%h c=%b o=%b",
                         i, ra, rb, rs, rc, s, cout, ovf, es, ec, eo);
            end
            last_s = es;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] es;
        logic         ec, eo;
        int lat, seen;
        a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        n_checks++; if ({done, s, cout, ovf} !== 11'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs got d=%b s=%h c=%b o=%b want all 0", done, s, cout, ovf);
        end
        seen = 0;
        repeat (2) begin @(negedge clk); if (done === 1'b1) seen = 1; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done === 1'b1) seen = 1; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_done got %0d want 0", seen); end
        model(8'h7F, 8'h01, 1'b0, 1'b0, es, ec, eo);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL after_reset_latency got %0d want 8", lat); end
        n_checks++; if (s !== es) begin n_fail++; $display("FAIL after_reset_s got %h want %h", s, es); end
        n_checks++; if (cout !== ec) begin n_fail++; $display("FAIL after_reset_cout got %b want %b", cout, ec); end
        n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL after_reset_ovf got %b want %b", ovf, eo); end
        @(negedge clk);
    endtask

    task automatic test_final();
        n_checks++; if (both_hi !== 0) begin n_fail++; $display("FAIL busy_and_done_overlap got %0d want 0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_final();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
